psec6_readout_sequencer: RTL
============================

Name: psec6_readout_sequencer

Overview:
- Chip-level controller that drains timestamp and trigger-count registers from all channel digital blocks after sampling stops.
- For each enabled channel it:
  - pulses that channel's INST_READOUT,
  - steps SELECT_REG through every register,
  - deserializes the channel's CNT_SER bit stream,
  - emits one tagged word per register on a valid/ready interface toward the SPI output FIFO.
- Runs on SPI_CLK and replaces manual register-by-register readout over SPI.

Parameters:
- NUM_CH, 8, number of channel digital blocks served (CH_W = clog2(NUM_CH), min 1).
- NUM_REG, 6, registers per channel; SELECT_REG values 0..NUM_REG-1.
- REG_BITS, 10, serial length of timestamp registers (SELECT_REG 0..NUM_REG-2).
- CNT_BITS, 3, serial length of the trigger-count register (SELECT_REG = NUM_REG-1).

Ports:
- SPI_CLK  input  1  sole clock; all state changes on its rising edge.
- RSTB  input  1  asynchronous active-low reset.
- RD_START  input  1  single-cycle request to begin a readout pass.
- RD_ABORT  input  1  single-cycle request to cancel the pass in progress.
- CH_MASK  input  NUM_CH  channel enable bits; latched at accepted RD_START.
- CNT_SER  input  NUM_CH  serial data from each channel, MSB first.
- WORD_READY  input  1  downstream accepts WORD_DATA.
- INST_READOUT  output  NUM_CH  one-hot load/readout strobe to the selected channel.
- SELECT_REG  output  3  register select broadcast to all channels.
- WORD_DATA  output  REG_BITS+3+CH_W  {ch_index, reg_index[2:0], data[REG_BITS-1:0]}.
- WORD_VALID  output  1  WORD_DATA valid.
- BUSY  output  1  pass in progress.
- DONE  output  1  one-cycle pulse at normal pass completion.

Behaviour:
- Reset: all outputs 0; state IDLE; ch, reg and bit counters 0; mask latch 0.
- States: IDLE, LOAD, SHIFT, EMIT.
- IDLE:
  - BUSY=0.
  - RD_START=1 with CH_MASK!=0: latch mask; ch = lowest set bit; reg=0; go to LOAD.
  - RD_START=1 with CH_MASK==0: DONE pulses next cycle; stay IDLE.
- LOAD:
  - Exactly 1 cycle: INST_READOUT[ch]=1, all other bits 0; SELECT_REG=reg; bitcnt cleared; data shifter cleared.
  - Next state is SHIFT.
- SHIFT:
  - Length is L cycles: L=CNT_BITS when reg==NUM_REG-1, else L=REG_BITS.
  - Each cycle: data <= {data[REG_BITS-2:0], CNT_SER[ch]}.
  - After L samples, data holds the value right-aligned and zero-extended; go to EMIT.
  - SELECT_REG is held stable throughout; INST_READOUT=0.
- EMIT:
  - WORD_VALID=1; WORD_DATA stable until handshake (WORD_VALID & WORD_READY same cycle).
  - On handshake with reg<NUM_REG-1: reg++, go to LOAD.
  - On handshake with reg==NUM_REG-1: ch = next higher set bit in the latched mask, reg=0, go to LOAD.
  - If no higher set bit exists: go to IDLE, DONE=1 for that one cycle.
  - WORD_VALID deasserts in the cycle after the handshake.
- Per-word latency: 1 (LOAD) + L (SHIFT) + 1 (EMIT, zero backpressure) = 12 cycles for timestamps, 5 for trigger count.
- Pass length: 5*12 + 5 = 65 cycles per enabled channel with WORD_READY tied high.
- BUSY=1 in every state except IDLE.
- RD_START while BUSY: ignored; CH_MASK changes mid-pass: ignored (latched copy used).
- RD_ABORT:
  - Any non-IDLE state goes to IDLE next cycle.
  - WORD_VALID and INST_READOUT drop; DONE is not pulsed.
  - RD_START and RD_ABORT in the same cycle while IDLE: abort wins, no pass starts.
- Backpressure: unbounded stall in EMIT permitted; no data loss, no counter advance.
- RSTB assertion mid-pass: immediate return to reset values; a partially shifted word is discarded.

Test Plan:
- Basic pass:
  - Stimulus: CH_MASK=8'b0000_0001, channel 0 model serializes CE..CA = 0x3FF,0x000,0x2AA,0x155,0x001 and trigger_cnt=3'b101, WORD_READY=1.
  - Required: 6 words, reg 0..5; the trigger-count word has data=10'h005, ch=0; DONE pulses at cycle 65 after start.
- Sparse mask:
  - Stimulus: CH_MASK=8'b1000_0100.
  - Required: words from ch 2 then ch 7 only; INST_READOUT seen only as 8'h04 then 8'h80, each one cycle per register (12 strobes total).
- Backpressure:
  - Stimulus: hold WORD_READY=0 for 20 cycles at the first EMIT.
  - Required: WORD_DATA constant, SELECT_REG unchanged, no LOAD; pass completes 20 cycles late with identical words.
- Empty mask and ignored restart:
  - Stimulus: RD_START with CH_MASK=0, then RD_START again mid-pass.
  - Required: first gives DONE one cycle later with BUSY never set; second has no effect on word sequence.
- Abort:
  - Stimulus: RD_ABORT during SHIFT of ch 0 reg 2.
  - Required: next cycle BUSY=0, WORD_VALID=0; no DONE; a following RD_START restarts at reg 0.
- Reset mid-pass:
  - Stimulus: drop RSTB asynchronously during EMIT.
  - Required: all outputs 0 before the next SPI_CLK edge; no word is emitted after release until a new RD_START.

Source files
------------

// File: rtl/psec6_readout_sequencer.sv
// rtl/psec6_readout_sequencer.sv - drains every enabled channel's timestamp and trigger-count registers
// into tagged words on a valid/ready stream.
module psec6_readout_sequencer #(
    parameter int NUM_CH   = 8,
    parameter int NUM_REG  = 6,
    parameter int REG_BITS = 10,
    parameter int CNT_BITS = 3,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       SPI_CLK,
    input  logic                       RSTB,
    input  logic                       RD_START,
    input  logic                       RD_ABORT,
    input  logic [NUM_CH-1:0]          CH_MASK,
    input  logic [NUM_CH-1:0]          CNT_SER,
    input  logic                       WORD_READY,
    output logic [NUM_CH-1:0]          INST_READOUT,
    output logic [2:0]                 SELECT_REG,
    output logic [REG_BITS+3+CH_W-1:0] WORD_DATA,
    output logic                       WORD_VALID,
    output logic                       BUSY,
    output logic                       DONE
);

    localparam int BC_W = $clog2(REG_BITS + 1);
    localparam logic [2:0] REG_LAST = 3'(NUM_REG - 1);
    localparam logic [NUM_CH-1:0] ONE_HOT = NUM_CH'(1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, EMIT} state_t;

    state_t              state_q;
    logic [NUM_CH-1:0]   mask_q;
    logic [CH_W-1:0]     ch_q;
    logic [2:0]          reg_q;
    logic [BC_W-1:0]     bitcnt_q;
    logic [REG_BITS-1:0] data_q;

    logic [CH_W-1:0]     first_ch;
    logic [CH_W-1:0]     next_ch;
    logic                next_found;
    logic [BC_W-1:0]     last_bit;
    logic [REG_BITS-1:0] data_d;

    // Descending scan so the lowest qualifying index is the one that sticks.
    always_comb begin
        first_ch   = '0;
        next_ch    = '0;
        next_found = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (CH_MASK[i]) first_ch = CH_W'(i);
            if (mask_q[i] && (i > int'(ch_q))) begin
                next_ch    = CH_W'(i);
                next_found = 1'b1;
            end
        end
    end

    assign last_bit = (reg_q == REG_LAST) ? BC_W'(CNT_BITS - 1) : BC_W'(REG_BITS - 1);
    assign data_d   = {data_q[REG_BITS-2:0], CNT_SER[ch_q]};

    always_ff @(posedge SPI_CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q      <= IDLE;
            mask_q       <= '0;
            ch_q         <= '0;
            reg_q        <= '0;
            bitcnt_q     <= '0;
            data_q       <= '0;
            INST_READOUT <= '0;
            SELECT_REG   <= '0;
            WORD_DATA    <= '0;
            WORD_VALID   <= 1'b0;
            BUSY         <= 1'b0;
            DONE         <= 1'b0;
        end else begin
            DONE         <= 1'b0;
            INST_READOUT <= '0;
            if (RD_ABORT) begin
                state_q    <= IDLE;
                WORD_VALID <= 1'b0;
                BUSY       <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (RD_START && (CH_MASK != '0)) begin
                            mask_q       <= CH_MASK;
                            ch_q         <= first_ch;
                            reg_q        <= '0;
                            SELECT_REG   <= '0;
                            INST_READOUT <= ONE_HOT << first_ch;
                            BUSY         <= 1'b1;
                            state_q      <= LOAD;
                        end else if (RD_START) begin
                            DONE <= 1'b1;
                        end
                    end
                    LOAD: begin
                        bitcnt_q <= '0;
                        data_q   <= '0;
                        state_q  <= SHIFT;
                    end
                    SHIFT: begin
                        data_q   <= data_d;
                        bitcnt_q <= bitcnt_q + 1'b1;
                        if (bitcnt_q == last_bit) begin
                            WORD_DATA  <= {ch_q, reg_q, data_d};
                            WORD_VALID <= 1'b1;
                            state_q    <= EMIT;
                        end
                    end
                    EMIT: begin
                        if (WORD_READY) begin
                            WORD_VALID <= 1'b0;
                            if (reg_q != REG_LAST) begin
                                reg_q        <= reg_q + 3'd1;
                                SELECT_REG   <= reg_q + 3'd1;
                                INST_READOUT <= ONE_HOT << ch_q;
                                state_q      <= LOAD;
                            end else if (next_found) begin
                                ch_q         <= next_ch;
                                reg_q        <= '0;
                                SELECT_REG   <= '0;
                                INST_READOUT <= ONE_HOT << next_ch;
                                state_q      <= LOAD;
                            end else begin
                                BUSY    <= 1'b0;
                                DONE    <= 1'b1;
                                state_q <= IDLE;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule
